cpucfg_unit: RTL and testbench

Back-end execution unit for the LoongArch `CPUCFG` instruction. It is the requesting side of the CPU-configuration lookup. It accepts one issued `CPUCFG` micro-op, drives the configuration word index to the combinational configuration table, and captures the returned value. It then presents the result on a writeback port with a valid/ready handshake, honouring pipeline flushes and counting completed operations.

---
 rtl/cpucfg_unit.sv | 130 +++++++++++++
 tb/tb_cpucfg_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpucfg_unit.sv
// CPUCFG execution unit: latches one micro-op, looks up the config word, and writes it back.
// Latency: accept edge T, table lookup in cycle T+1, result valid in cycle T+2. Initiation interval is 3 cycles or more.
// Backpressure: the unit holds the result in WB until wb_ready. issue_ready stays low while an op is held.
module cpucfg_unit #(
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [31:0]       issue_src,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [ROB_W-1:0]  issue_rob,
    output logic [31:0]       cpuconf_id,
    input  logic [31:0]       cpuconf_value,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [PREG_W-1:0] wb_pd,
    output logic [ROB_W-1:0]  wb_rob,
    output logic              busy,
    output logic [31:0]       cfg_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WB     = 2'd2
    } state_t;

    typedef struct packed {
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
    } tag_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] id_q;
    logic [31:0] data_q;
    tag_t        tag_q;
    logic [31:0] cnt_q;

    logic        accept;
    logic        capture;
    logic        wb_done;
    logic        id_in_range;

    // The table only decodes index bits [4:0]. Indices above that range return zero here.
    assign id_in_range = (id_q[31:5] == 27'd0);

    always_comb begin
        state_d     = state_q;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        wb_done     = 1'b0;
        case (state_q)
            IDLE: begin
                issue_ready = ~flush;
                if (issue_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                capture = ~flush;
                state_d = WB;
            end
            WB: begin
                wb_valid = ~flush;
                if (wb_ready && !flush) begin
                    wb_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush kills the op in any state. The result is dropped and nothing is counted.
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q  <= 32'd0;
            tag_q <= '0;
        end else if (accept) begin
            id_q      <= issue_src;
            tag_q.pd  <= issue_pd;
            tag_q.rob <= issue_rob;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= 32'd0;
        end else if (capture) begin
            data_q <= id_in_range ? cpuconf_value : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 32'd0;
        end else if (wb_done) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // The table index is taken from a register, so no combinational path runs from the issue port to the table.
    assign cpuconf_id = id_q;
    assign wb_data    = data_q;
    assign wb_pd      = tag_q.pd;
    assign wb_rob     = tag_q.rob;
    assign busy       = (state_q != IDLE);
    assign cfg_cnt    = cnt_q;

endmodule

// File: tb/tb_cpucfg_unit.sv
// Bench for cpucfg_unit. It runs directed and random CPUCFG ops against a transaction-level reference.
module tb_cpucfg_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_src;
    logic [5:0]  issue_pd;
    logic [5:0]  issue_rob;
    logic [31:0] cpuconf_id;
    logic [31:0] cpuconf_value;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [5:0]  wb_pd;
    logic [5:0]  wb_rob;
    logic        busy;
    logic [31:0] cfg_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_cnt = 32'd0;

    localparam int M_NONE        = 0;
    localparam int M_FLUSH_LOOK  = 1;
    localparam int M_FLUSH_WB    = 2;
    localparam int M_FLUSH_IDLE  = 3;
    localparam int M_RESET_WB    = 4;

    cpucfg_unit #(.PREG_W(6), .ROB_W(6)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_src    (issue_src),
        .issue_pd     (issue_pd),
        .issue_rob    (issue_rob),
        .cpuconf_id   (cpuconf_id),
        .cpuconf_value(cpuconf_value),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_pd        (wb_pd),
        .wb_rob       (wb_rob),
        .busy         (busy),
        .cfg_cnt      (cfg_cnt)
    );

    always #5 clk = ~clk;

    // Configuration table model. Like the real table, it decodes only the low 5 index bits.
    function automatic logic [31:0] table_word(input logic [4:0] idx);
        case (idx)
            5'd1:    return 32'h0001_F1F4;
            5'd16:   return 32'h0000_0005;
            5'd17:   return 32'h0408_0001;
            default: return 32'hC0DE_0000 | {27'd0, idx};
        endcase
    endfunction

    always_comb cpuconf_value = table_word(cpuconf_id[4:0]);

    // Architectural result of CPUCFG rj: indices 32 and above return zero.
    function automatic logic [31:0] ref_word(input logic [31:0] src);
        if (src > 32'd31) return 32'd0;
        return table_word(src[4:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cpuconf_id"}, cpuconf_id, 32'd0);
        check({tag, ".wb_valid"},   {31'd0, wb_valid}, 32'd0);
        check({tag, ".wb_data"},    wb_data, 32'd0);
        check({tag, ".wb_pd"},      {26'd0, wb_pd}, 32'd0);
        check({tag, ".wb_rob"},     {26'd0, wb_rob}, 32'd0);
        check({tag, ".busy"},       {31'd0, busy}, 32'd0);
        check({tag, ".cfg_cnt"},    cfg_cnt, 32'd0);
    endtask

    // Runs one op. The task starts at a negedge with the DUT in IDLE and ends at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [31:0] src, input logic [5:0] pd, input logic [5:0] rob,
                          input int stall, input int mode);
        logic [31:0] exp_data;
        logic        fl;
        exp_data = ref_word(src);

        issue_valid = 1'b1;
        issue_src   = src;
        issue_pd    = pd;
        issue_rob   = rob;
        flush       = (mode == M_FLUSH_IDLE);
        wb_ready    = $urandom_range(0, 1);
        #1;
        check("idle.issue_ready", {31'd0, issue_ready}, {31'd0, !flush});
        check("idle.busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        flush       = 1'b0;
        if (mode == M_FLUSH_IDLE) begin
            #1;
            check("flush_idle.busy", {31'd0, busy}, 32'd0);
            check("flush_idle.cnt", cfg_cnt, exp_cnt);
            return;
        end

        // LOOKUP cycle. The issue port is scrambled here to show the table index is registered.
        issue_src = $urandom;
        issue_pd  = 6'($urandom);
        issue_rob = 6'($urandom);
        flush     = (mode == M_FLUSH_LOOK);
        #1;
        check("look.cpuconf_id", cpuconf_id, src);
        check("look.busy", {31'd0, busy}, 32'd1);
        check("look.issue_ready", {31'd0, issue_ready}, 32'd0);
        check("look.wb_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        if (mode == M_FLUSH_LOOK) begin
            #1;
            check("flush_look.busy", {31'd0, busy}, 32'd0);
            check("flush_look.wb_valid", {31'd0, wb_valid}, 32'd0);
            check("flush_look.cnt", cfg_cnt, exp_cnt);
            return;
        end

        if (mode == M_RESET_WB) begin
            rstn = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            exp_cnt = 32'd0;
            @(posedge clk);
            @(negedge clk);
            rstn = 1'b1;
            #1;
            check("async_rst.issue_ready", {31'd0, issue_ready}, 32'd1);
            return;
        end

        fl = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            wb_ready = (i == stall);
            fl       = (mode == M_FLUSH_WB) && (i == stall);
            flush    = fl;
            #1;
            check("wb.valid", {31'd0, wb_valid}, {31'd0, !fl});
            check("wb.data", wb_data, exp_data);
            check("wb.pd", {26'd0, wb_pd}, {26'd0, pd});
            check("wb.rob", {26'd0, wb_rob}, {26'd0, rob});
            check("wb.issue_ready", {31'd0, issue_ready}, 32'd0);
            check("wb.busy", {31'd0, busy}, 32'd1);
            check("wb.cnt_before", cfg_cnt, exp_cnt);
            @(posedge clk);
            @(negedge clk);
        end
        flush    = 1'b0;
        wb_ready = 1'b0;
        if (!fl) exp_cnt = exp_cnt + 32'd1;
        #1;
        check("after.busy", {31'd0, busy}, 32'd0);
        check("after.cnt", cfg_cnt, exp_cnt);
        check("after.issue_ready", {31'd0, issue_ready}, 32'd1);
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_src   = 32'd0;
        issue_pd    = 6'd0;
        issue_rob   = 6'd0;
        wb_ready    = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset.issue_ready", {31'd0, issue_ready}, 32'd1);
        flush = 1'b1;
        #1;
        check("reset.issue_ready_flush", {31'd0, issue_ready}, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'd1, 6'd5, 6'd9, 0, M_NONE);
        check("basic.cnt", cfg_cnt, 32'd1);
        run_op(32'd17, 6'd3, 6'd4, 0, M_NONE);
        run_op(32'd16, 6'd7, 6'd8, 0, M_NONE);
        run_op(32'h0000_0031, 6'd1, 6'd2, 0, M_NONE);
        run_op(32'h8000_0001, 6'd1, 6'd2, 1, M_NONE);
        run_op(32'd31, 6'd63, 6'd63, 0, M_NONE);
        run_op(32'd32, 6'd10, 6'd11, 0, M_NONE);
        run_op(32'd2, 6'd12, 6'd13, 4, M_NONE);
        run_op(32'd3, 6'd14, 6'd15, 0, M_FLUSH_LOOK);
        run_op(32'd4, 6'd16, 6'd17, 0, M_FLUSH_WB);
        run_op(32'd5, 6'd18, 6'd19, 2, M_FLUSH_WB);
        run_op(32'd6, 6'd20, 6'd21, 0, M_FLUSH_IDLE);
        run_op(32'd17, 6'd22, 6'd23, 1, M_RESET_WB);
        run_op(32'd1, 6'd5, 6'd9, 0, M_NONE);
        check("post_reset.cnt", cfg_cnt, 32'd1);

        // Random ops
        for (int n = 0; n < 60; n++) begin
            logic [31:0] src;
            int          mode;
            int          r;
            src  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            r    = $urandom_range(0, 19);
            mode = (r < 14) ? M_NONE : (r < 16) ? M_FLUSH_LOOK : (r < 18) ? M_FLUSH_WB :
                   (r < 19) ? M_FLUSH_IDLE : M_RESET_WB;
            run_op(src, 6'($urandom), 6'($urandom), $urandom_range(0, 4), mode);
            // Idle gap with issue_valid low: the unit must stay idle.
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                check("gap.busy", {31'd0, busy}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
